fix_to_fp_11_6: RTL
===================

FIX_TO_FP_11_6 -- requirements
Module: fix_to_fp_11_6

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the clock port SHALL be named clk and the reset port rst_n.
REQ-002 Parameter IN_W, default 16, SHALL set the signed two's-complement input width (valid range 4..64).
REQ-003 Parameter FRAC_BITS, default 8, SHALL set the number of input fraction bits (valid range 0..IN_W-1).
REQ-004 Ports (name  direction  width  meaning):
  clk          in   1       rising-edge clock
  rst_n        in   1       async active-low reset
  in_valid     in   1       in_data valid
  in_ready     out  1       block accepts in_data this cycle
  in_data      in   IN_W    signed fixed-point value
  out_valid    out  1       out_data valid
  out_ready    in   1       consumer accepts out_data
  out_data     out  20      FloPoCo wE=11, wF=6 float
  out_inexact  out  1       rounding discarded nonzero bits

Function
REQ-005 out_data SHALL use the following field layout: [19:18] exception (00 zero, 01 normal); [17] sign; [16:6] biased exponent (bias 1023); [5:0] fraction.
REQ-006 Exception codes 10 (inf) and 11 (NaN) SHALL never be produced.
REQ-007 The datapath SHALL be a 3-stage pipeline.
  - S1: capture the sign and the absolute value, as an IN_W-bit unsigned quantity (so -2^(IN_W-1) is representable).
  - S2: leading-one detect and left-normalize.
  - S3: round and pack.
REQ-008 Global advance SHALL be enable = !out_valid || out_ready; in_ready SHALL equal enable.
REQ-009 A transfer SHALL occur on in_valid && in_ready; a bubble SHALL advance when in_valid is low.
REQ-010 Latency SHALL be 3 cycles from the input handshake to out_valid.
REQ-011 Throughput SHALL be 1 value per cycle while out_ready is high.
REQ-012 While stalled, all stage registers, out_data and out_inexact SHALL hold.
REQ-013 For a nonzero input with leading-one position p, the exponent SHALL be 1023 + p - FRAC_BITS.
REQ-014 Rounding SHALL be round-to-nearest, ties-to-even, using the guard bit and the OR of all lower bits as sticky.
REQ-015 A mantissa carry-out SHALL clear the fraction and increment the exponent.
REQ-016 out_inexact SHALL be 1 when the guard bit or any sticky bit is 1, and 0 otherwise.
REQ-017 A zero input SHALL produce out_data = 0x00000 with out_inexact = 0; negative zero SHALL never be produced.
REQ-018 No exponent overflow or underflow SHALL be possible within the parameter ranges; no saturation logic SHALL be present.

Reset
REQ-019 While rst_n is low, all stage valid flags, out_valid, out_data and out_inexact SHALL be 0, and in_ready SHALL be 1.
REQ-020 Assertion of rst_n mid-operation SHALL discard all in-flight values immediately (asynchronously).
REQ-021 After release of rst_n, the first output SHALL appear 3 cycles after the first accepted input.

Configuration
REQ-022 With macro FIX_TO_FP_INEXACT_EN defined, out_inexact SHALL be computed per REQ-016 and pipelined alongside out_data.
REQ-023 Without FIX_TO_FP_INEXACT_EN, out_inexact SHALL be tied to 0 and no inexact state SHALL be registered; out_data SHALL be identical in both builds.

Verification (IN_W=16, FRAC_BITS=8, FIX_TO_FP_INEXACT_EN defined)
REQ-024 in_data 0x0100 (1.0), out_ready=1 -> out_data 0x4FFC0, out_inexact 0, out_valid asserted exactly 3 cycles after the handshake.
REQ-025 Input 0x0000, then 0xFF00 (-1.0), then 0x8000 (-128.0) on consecutive cycles -> outputs on consecutive cycles: 0x00000, 0x6FFC0, 0x70180; out_inexact 0 for each.
REQ-026 Input 0x01FF (1.99609375) -> out_data 0x50000 (2.0, round-up carry), out_inexact 1. Input 0x0102 (tie, even LSB) -> out_data 0x4FFC0, out_inexact 1.
REQ-027 Backpressure:
  - Hold out_ready=0 and offer 5 inputs -> exactly 3 accepted, then in_ready=0, out_data stable.
  - Raise out_ready -> all values delivered in order with no loss or duplication.
REQ-028 Reset mid-operation:
  - Pull rst_n low with 3 values in flight -> out_valid=0 and out_data=0x00000 immediately.
  - After release, no stale outputs appear.
REQ-029 Build without FIX_TO_FP_INEXACT_EN and repeat REQ-026 -> same out_data, out_inexact 0.

Source files
------------

// File: rtl/fix_to_fp_11_6.sv
// Signed fixed-point to FloPoCo float (wE=11, wF=6), RNE rounding; FIX_TO_FP_INEXACT_EN adds out_inexact.
// Latency: 3 cycles from the input handshake to out_valid, 1 value per cycle.
// Backpressure: one global enable (!out_valid || out_ready) freezes every stage; in_ready equals it.
module fix_to_fp_11_6 #(
    parameter int IN_W      = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [19:0]     out_data,
    output logic            out_inexact
);

    localparam int          EXT_W    = IN_W + 8;
    localparam logic [10:0] EXP_BASE = 11'(1023 - FRAC_BITS);

    logic w_en;

    // S1 state: sign and magnitude; the magnitude is unsigned so -2^(IN_W-1) survives
    logic            r_s1_vld;
    logic            r_s1_sign;
    logic [IN_W-1:0] r_s1_abs;
    logic [IN_W-1:0] w_s1_abs;

    // S2 state: mantissa left-aligned so its leading one sits in the MSB
    logic            r_s2_vld;
    logic            r_s2_sign;
    logic [IN_W-1:0] r_s2_norm;
    logic [10:0]     r_s2_exp;
    logic [6:0]      w_lod_pos;
    logic [IN_W-1:0] w_s2_norm;
    logic [10:0]     w_s2_exp;

    // S3 round and pack
    logic             r_out_vld;
    logic [19:0]      r_out_dat;
    logic [EXT_W-1:0] w_ext;
    logic [5:0]       w_frac;
    logic             w_guard;
    logic             w_sticky;
    logic             w_round_up;
    logic [6:0]       w_frac_rnd;
    logic [10:0]      w_exp_rnd;
    logic             w_nonzero;
    logic [19:0]      w_s3_dat;

    assign w_en     = !r_out_vld || out_ready;
    assign in_ready = w_en;

    assign w_s1_abs = in_data[IN_W-1] ? -in_data : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_abs  <= '0;
        end else if (w_en) begin
            r_s1_vld  <= in_valid;
            r_s1_sign <= in_data[IN_W-1];
            r_s1_abs  <= w_s1_abs;
        end
    end

    always_comb begin
        w_lod_pos = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (r_s1_abs[i]) begin
                w_lod_pos = 7'(i);
            end
        end
    end

    assign w_s2_norm = r_s1_abs << (7'(IN_W - 1) - w_lod_pos);
    assign w_s2_exp  = EXP_BASE + 11'(w_lod_pos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_sign <= 1'b0;
            r_s2_norm <= '0;
            r_s2_exp  <= '0;
        end else if (w_en) begin
            r_s2_vld  <= r_s1_vld;
            r_s2_sign <= r_s1_sign;
            r_s2_norm <= w_s2_norm;
            r_s2_exp  <= w_s2_exp;
        end
    end

    // Zero-padding on the right keeps six fraction bits plus guard available even for narrow inputs.
    // A zero input normalizes to all zeros, so the MSB doubles as the nonzero flag.
    assign w_ext      = {r_s2_norm, 8'b0};
    assign w_nonzero  = r_s2_norm[IN_W-1];
    assign w_frac     = w_ext[EXT_W-2 -: 6];
    assign w_guard    = w_ext[EXT_W-8];
    assign w_sticky   = |w_ext[EXT_W-9:0];
    assign w_round_up = w_guard && (w_sticky || w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {6'b0, w_round_up};
    assign w_exp_rnd  = r_s2_exp + {10'b0, w_frac_rnd[6]};
    assign w_s3_dat   = w_nonzero ? {2'b01, r_s2_sign, w_exp_rnd, w_frac_rnd[5:0]} : 20'h00000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else if (w_en) begin
            r_out_vld <= r_s2_vld;
            r_out_dat <= w_s3_dat;
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_dat;

`ifdef FIX_TO_FP_INEXACT_EN
    logic r_out_inx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_inx <= 1'b0;
        end else if (w_en) begin
            r_out_inx <= w_guard || w_sticky;
        end
    end

    assign out_inexact = r_out_inx;
`else
    assign out_inexact = 1'b0;
`endif

endmodule
